// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: default parameter
// values, the address-width helper and the default register address type.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS   = 1;

  // Smallest n with 2**n >= value. Evaluated at elaboration time only.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  localparam int DEF_ADDR_W = clog2(DEF_NUM_REGS);

  // Register address for the default configuration.
  typedef logic [DEF_ADDR_W-1:0] regAddrT;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, the per-port Busy
// flags and the population count of pending registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic [NUM_RD*clog2(NUM_REGS)-1:0]   RA,
  input  logic [clog2(NUM_REGS)-1:0]          RW,
  input  logic                                RegWr,
  input  logic                                ResvWr,
  input  logic [clog2(NUM_REGS)-1:0]          ResvAddr,
  output logic [NUM_RD-1:0]                   Busy,
  output logic [clog2(NUM_REGS):0]            PendCnt
);

  localparam int ADDR_W = clog2(NUM_REGS);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pendNext;
  logic                resvValid;
  logic [ADDR_W-1:0]   busyAddr;

  // Register 0 is hardwired when ZERO_REG is set, so it can never be reserved.
  assign resvValid = ResvWr && !((ZERO_REG != 0) && (ResvAddr == '0));

  // Next pending vector: the write clears first, the reservation then wins
  // on a same-address collision.
  always_comb begin
    pendNext = pend;
    if (RegWr) begin
      pendNext[RW] = 1'b0;
    end
    if (resvValid) begin
      pendNext[ResvAddr] = 1'b1;
    end
  end

  // Pending bits; asynchronous reset drops every outstanding reservation.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pend <= '0;
    end else begin
      pend <= pendNext;
    end
  end

  // Population count of the registered pending bits; purely combinational
  // from the flops, so it changes on exactly the same edge as they do.
  always_comb begin
    PendCnt = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      PendCnt = PendCnt + (ADDR_W + 1)'(pend[k]);
    end
  end

  // Busy per read port: pending, unless this cycle's write is forwarded.
  always_comb begin
    Busy     = '0;
    busyAddr = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      busyAddr = RA[i*ADDR_W +: ADDR_W];
      Busy[i]  = pend[busyAddr] &&
                 !((BYPASS != 0) && RegWr && (RW == busyAddr));
    end
  end

endmodule

// File: rtl/multiport_regfile.sv
// Multiport register file: NUM_RD combinational read ports, one write port,
// optional hardwired-zero register 0, optional write-to-read forwarding and a
// pending-write scoreboard for destination reservation.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic [NUM_RD*clog2(NUM_REGS)-1:0]   RA,
  output logic [NUM_RD*DATA_W-1:0]            BusR,
  output logic [NUM_RD-1:0]                   Busy,
  input  logic [clog2(NUM_REGS)-1:0]          RW,
  input  logic [DATA_W-1:0]                   BusW,
  input  logic                                RegWr,
  input  logic                                ResvWr,
  input  logic [clog2(NUM_REGS)-1:0]          ResvAddr,
  output logic [clog2(NUM_REGS):0]            PendCnt,
  output logic [NUM_REGS*DATA_W-1:0]          RegDump
);

  localparam int ADDR_W = clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wrEn;
  logic              wrToZero;
  logic [ADDR_W-1:0] rdAddr;

  assign wrToZero = (ZERO_REG != 0) && (RW == '0);
  assign wrEn     = RegWr && !wrToZero;

  // Data array; register 0 is simply never written when it is hardwired.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else if (wrEn) begin
      regs[RW] <= BusW;
    end
  end

  // Read ports: array lookup, same-cycle forwarding, then the zero override.
  always_comb begin
    BusR   = '0;
    rdAddr = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rdAddr = RA[i*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (rdAddr == '0)) begin
        BusR[i*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && RegWr && (RW == rdAddr)) begin
        BusR[i*DATA_W +: DATA_W] = BusW;
      end else begin
        BusR[i*DATA_W +: DATA_W] = regs[rdAddr];
      end
    end
  end

  // Flattened, un-forwarded view of the array for co-simulation.
  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : genDump
      assign RegDump[g*DATA_W +: DATA_W] = regs[g];
    end
  endgenerate

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) uScoreboard (
    .Clk      (Clk),
    .Rst      (Rst),
    .RA       (RA),
    .RW       (RW),
    .RegWr    (RegWr),
    .ResvWr   (ResvWr),
    .ResvAddr (ResvAddr),
    .Busy     (Busy),
    .PendCnt  (PendCnt)
  );

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, register count (power of two, at least 2)
- NUM_RD, 2, number of read ports (1 to 4)
- ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes
- BYPASS, 1, when 1, a same-cycle write is forwarded to the read ports
REQ-002 ADDR_W SHALL be derived as clog2(NUM_REGS) and SHALL NOT be a parameter.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning:
- Clk, in, 1, single clock; all state updates on the rising edge
- Rst, in, 1, reset, asynchronous and active-low
- RA, in, NUM_RD*ADDR_W, read addresses; port i uses slice i
- BusR, out, NUM_RD*DATA_W, read data; port i uses slice i
- Busy, out, NUM_RD, bit i is set when port i's register has a pending write not satisfied this cycle
- RW, in, ADDR_W, write address
- BusW, in, DATA_W, write data
- RegWr, in, 1, write enable
- ResvWr, in, 1, reserve request: mark a destination register pending
- ResvAddr, in, ADDR_W, register to reserve
- PendCnt, out, ADDR_W+1, number of registers currently pending
- RegDump, out, NUM_REGS*DATA_W, flattened view of all registers for co-simulation

Function
REQ-004 Reads SHALL be combinational: BusR[i] = reg[RA[i]], with zero added latency.
REQ-005 When RegWr=1, reg[RW] SHALL take the value BusW on the rising edge of Clk.
REQ-006 When BYPASS=1 and RegWr=1 and RW==RA[i], BusR[i] SHALL equal BusW in the same cycle. This excludes the case ZERO_REG=1 with address 0.
REQ-007 When ZERO_REG=1, writes to address 0 SHALL be discarded and BusR for address 0 SHALL be 0. Reservations of address 0 SHALL also be discarded.
REQ-008 Each register SHALL have a pending bit (scoreboard):
- ResvWr=1 sets pend[ResvAddr] at the rising edge.
- RegWr=1 clears pend[RW] at the rising edge.
REQ-009 When ResvWr and RegWr target the same address in the same cycle, the reservation SHALL win and the pending bit SHALL end the cycle at 1. The data write still occurs.
REQ-010 A reservation of an already-pending register SHALL leave it pending and SHALL NOT change PendCnt.
REQ-011 A write to a non-pending register SHALL update the data and SHALL NOT change any pending bit.
REQ-012 Busy[i] SHALL be pend[RA[i]] AND NOT (BYPASS=1 AND RegWr=1 AND RW==RA[i]).
REQ-013 PendCnt SHALL equal the population count of the pending bits as registered. It SHALL be updated in the same edge as the pending bits, so it never lags them by a cycle.
REQ-014 RegDump slice k SHALL equal reg[k] as registered, with no bypass applied.
REQ-015 When multiple read ports address the same register, all of them SHALL return identical data and Busy values.

Reset
REQ-016 While Rst=0, every register, every pending bit and PendCnt SHALL be 0, asynchronously.
REQ-017 While Rst=0, the outputs SHALL be:
- BusR: 0, except any bypassed value
- Busy: 0
- RegDump: 0
REQ-018 Writes and reservations presented while Rst=0 SHALL be ignored. Deassertion SHALL take effect at the first rising edge after Rst returns to 1.
REQ-019 Asserting Rst mid-operation SHALL discard all pending reservations. No write SHALL complete in a cycle in which Rst is low.

Structure
REQ-020 The shared package regfile_pkg SHALL hold:
- the default parameter values
- the clog2 helper used for ADDR_W
- a typedef for the register address
REQ-021 The pending-bit logic and PendCnt SHALL live in the sub-module regfile_scoreboard. The data array and bypass logic SHALL live in the top level.

Verification
REQ-022 Basic write and read: reset, then write 0xDEADBEEF to r5, then read r5 on both ports in the next cycle -> BusR = 0xDEADBEEF on both ports and Busy = 00.
REQ-023 Bypass: write 0x12345678 to r7 while RA[0]=7 in the same cycle -> BusR[0] = 0x12345678 in that cycle. Repeat with BYPASS=0 -> BusR[0] shows the old value 0 in that cycle.
REQ-024 Zero register: write 0xFFFFFFFF to r0 and reserve r0 -> BusR = 0, Busy = 0 and PendCnt = 0.
REQ-025 Scoreboard: reserve r3, then r4 -> PendCnt = 2 and Busy=1 when reading r3. A later write to r3 -> PendCnt = 1. Reserving and writing r4 in the same cycle -> r4 remains pending and PendCnt = 1.
REQ-026 Reset mid-operation: with 3 registers pending and r9 = 0xA5A5A5A5, pulse Rst low between clock edges -> PendCnt = 0, r9 = 0 and RegDump is all zero immediately, before the next edge.
